// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared sizes, state encoding and row-slice helpers for the matrix row
// sequencer. Matrices are packed row 0 in the MSBs; within a row, element 0
// sits in the MSBs.
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int N      = 5;
    localparam int ROW_W  = N * ELEM_W;
    localparam int MAT_W  = N * ROW_W;

    // Row counters only need to reach N-1.
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // LSB position of row idx inside a packed matrix.
    function automatic int row_lsb(input int idx);
        return (N - 1 - idx) * ROW_W;
    endfunction

endpackage

// File: rtl/matrix_row_sequencer_row_valid_delay.sv
// -----------------------------------------------------------------------------
// row_valid_delay
// LAT-stage shift register that lines up the issued-row valid with the row
// returned by the attached unit. LAT = 0 is a plain wire.
//
// Ports:
//   clk_i  - system clock
//   rst_i  - synchronous reset, active-low
//   vld_i  - valid of the row currently presented to the attached unit
//   vld_o  - vld_i delayed by LAT cycles
// -----------------------------------------------------------------------------
module row_valid_delay #(
    parameter int LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_i,
    output logic vld_o
);

    if (LAT == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign vld_o = vld_i;
    end else begin : g_shift
        logic [LAT-1:0] sr_q;

        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                sr_q <= '0;
            end else begin
                sr_q[0] <= vld_i;
                for (int i = 1; i < LAT; i++) begin
                    sr_q[i] <= sr_q[i-1];
                end
            end
        end

        assign vld_o = sr_q[LAT-1];
    end

endmodule

// File: rtl/matrix_row_sequencer.sv
// -----------------------------------------------------------------------------
// matrix_row_sequencer
// Latches an N x N matrix on start, issues it one row per cycle to a
// row-level unit, captures the returned rows OP_LAT cycles later and
// reassembles them into result_o, then pulses done_o for one cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; result_o holds the last result
// ISSUE | presenting source rows 0..N-1, row_valid_out_o = 1
// DRAIN | all rows issued, waiting for the remaining captures
// DONE  | result complete, done_o = 1 for this single cycle
//
// Ports:
//   clk_i            - system clock, rising edge
//   rst_i            - synchronous reset, active-low
//   start_i          - begin operation, sampled only in IDLE
//   m_in_i           - source matrix (row 0 in MSBs)
//   row_out_o        - row presented to the attached unit
//   row_valid_out_o  - row_out_o holds a valid row
//   row_in_i         - row returned by the attached unit
//   result_o         - reassembled matrix, same packing as m_in_i
//   busy_o           - high whenever not IDLE
//   done_o           - one-cycle completion pulse
//   cycle_cnt_o      - busy-cycle count, only with MATRIX_ROWSEQ_CYCLE_CNT_EN
//
// Parameter OP_LAT (0..7): cycles from row_out_o to the matching row_in_i.
// Optional build macro: MATRIX_ROWSEQ_CYCLE_CNT_EN adds cycle_cnt_o.
// -----------------------------------------------------------------------------
module matrix_row_sequencer
    import matrix_pkg::*;
#(
    parameter int OP_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [MAT_W-1:0] m_in_i,
    output logic [ROW_W-1:0] row_out_o,
    output logic             row_valid_out_o,
    input  logic [ROW_W-1:0] row_in_i,
    output logic [MAT_W-1:0] result_o,
    output logic             busy_o,
    output logic             done_o
`ifdef MATRIX_ROWSEQ_CYCLE_CNT_EN
    ,
    output logic [7:0]       cycle_cnt_o
`endif
);

    seq_state_e       state_q;
    logic [ROW_W-1:0] src_q [N];
    logic [ROW_W-1:0] res_q [N];
    logic [ROW_W-1:0] m_rows [N];
    logic [CNT_W-1:0] issue_cnt_q;
    logic [CNT_W-1:0] issue_cnt_inc;
    logic [CNT_W-1:0] cap_cnt_q;
    logic [ROW_W-1:0] row_out_q;
    logic             row_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             vld_dly;
    logic             cap_last;

    always_comb begin
        result_o = '0;
        for (int r = 0; r < N; r++) begin
            m_rows[r] = m_in_i[row_lsb(r) +: ROW_W];
            result_o[row_lsb(r) +: ROW_W] = res_q[r];
        end
    end

    row_valid_delay #(
        .LAT (OP_LAT)
    ) u_vld_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .vld_i (row_valid_q),
        .vld_o (vld_dly)
    );

    assign issue_cnt_inc = issue_cnt_q + 1'b1;
    assign cap_last      = vld_dly && (cap_cnt_q == LAST_ROW);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            row_out_q   <= '0;
            row_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int r = 0; r < N; r++) begin
                src_q[r] <= '0;
                res_q[r] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q     <= ISSUE;
                        busy_q      <= 1'b1;
                        row_valid_q <= 1'b1;
                        // Row 0 goes out straight from m_in; src_q is loaded on the same edge.
                        row_out_q   <= m_rows[0];
                        issue_cnt_q <= '0;
                        cap_cnt_q   <= '0;
                        for (int r = 0; r < N; r++) begin
                            src_q[r] <= m_rows[r];
                            res_q[r] <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_cnt_q == LAST_ROW) begin
                        row_valid_q <= 1'b0;
                        issue_cnt_q <= '0;
                        // With a combinational unit the last capture lands on this edge.
                        if (cap_last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        issue_cnt_q <= issue_cnt_inc;
                        row_out_q   <= src_q[issue_cnt_inc];
                    end
                end
                DRAIN: begin
                    if (cap_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase

            if (vld_dly) begin
                res_q[cap_cnt_q] <= row_in_i;
                cap_cnt_q        <= cap_last ? '0 : cap_cnt_q + 1'b1;
            end
        end
    end

    assign row_out_o       = row_out_q;
    assign row_valid_out_o = row_valid_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

`ifdef MATRIX_ROWSEQ_CYCLE_CNT_EN
    logic [7:0] cyc_cnt_q;

    // Counts busy cycles up to and including the edge that raises done.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cyc_cnt_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            cyc_cnt_q <= '0;
        end else if (busy_q && !done_q && cyc_cnt_q != 8'hFF) begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
        end
    end

    assign cycle_cnt_o = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_matrix_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matrix_row_sequencer
// Three sequencers run side by side on shared stimulus:
//   lane 0: OP_LAT=0, combinational identity unit
//   lane 1: OP_LAT=1, registered element-wise negation unit
//   lane 2: OP_LAT=3, three-stage identity unit
// Expected behaviour per cycle after the start edge is derived from the
// cycle offset, the lane latency and the matrix latched at start.
// -----------------------------------------------------------------------------
module tb_matrix_row_sequencer;
    import matrix_pkg::*;

    localparam int LANES = 3;
    localparam int WIN   = N + 3 + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_b;
    logic             start;
    logic [MAT_W-1:0] m_in;

    logic [ROW_W-1:0] row_out   [LANES];
    logic [ROW_W-1:0] row_in    [LANES];
    logic [MAT_W-1:0] result    [LANES];
    logic             row_valid [LANES];
    logic             busy      [LANES];
    logic             done      [LANES];
`ifdef MATRIX_ROWSEQ_CYCLE_CNT_EN
    logic [7:0]       cycle_cnt [LANES];
`endif

    int n_checks = 0;
    int n_errs   = 0;

    logic [ROW_W-1:0] cur_rows [N];
    logic [ROW_W-1:0] alt_rows [N];

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 1 : 3;
    endfunction

    function automatic logic [ROW_W-1:0] neg_row(input logic [ROW_W-1:0] r);
        logic [ROW_W-1:0] o;
        logic [ELEM_W-1:0] e;
        o = '0;
        for (int k = 0; k < N; k++) begin
            e = r[(N-1-k)*ELEM_W +: ELEM_W];
            o[(N-1-k)*ELEM_W +: ELEM_W] = ~e + 1'b1;
        end
        return o;
    endfunction

    function automatic logic [ROW_W-1:0] lane_op(input int g, input logic [ROW_W-1:0] r);
        return (g == 1) ? neg_row(r) : r;
    endfunction

    function automatic logic [MAT_W-1:0] pack_rows(input logic [ROW_W-1:0] rows [N]);
        logic [MAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[(N-1-i)*ROW_W +: ROW_W] = rows[i];
        return m;
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        return ROW_W'({$urandom(), $urandom()});
    endfunction

    function automatic logic [MAT_W-1:0] rand_mat();
        logic [MAT_W-1:0] m;
        for (int i = 0; i < N; i++) m[(N-1-i)*ROW_W +: ROW_W] = rand_row();
        return m;
    endfunction

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int LAT = (g == 0) ? 0 : (g == 1) ? 1 : 3;

        matrix_row_sequencer #(
            .OP_LAT (LAT)
        ) u_dut (
            .clk_i           (clk),
            .rst_i           (rst_b),
            .start_i         (start),
            .m_in_i          (m_in),
            .row_out_o       (row_out[g]),
            .row_valid_out_o (row_valid[g]),
            .row_in_i        (row_in[g]),
            .result_o        (result[g]),
            .busy_o          (busy[g]),
            .done_o          (done[g])
`ifdef MATRIX_ROWSEQ_CYCLE_CNT_EN
            ,
            .cycle_cnt_o     (cycle_cnt[g])
`endif
        );

        if (LAT == 0) begin : g_comb
            assign row_in[g] = row_out[g];
        end else begin : g_pipe
            logic [ROW_W-1:0] pipe_q [LAT];
            always @(posedge clk) begin
                pipe_q[0] <= (g == 1) ? neg_row(row_out[g]) : row_out[g];
                for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
            end
            assign row_in[g] = pipe_q[LAT-1];
        end
    end

    task automatic check_val(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // j = cycles since the start edge; r_edge = offset of a reset edge (large if none).
    task automatic check_lane(input int g, input int j, input int r_edge);
        int L;
        bit live;
        logic [ROW_W-1:0] er [N];
        logic [MAT_W-1:0] exp_res;
        int exp_cnt;
        L    = lat_of(g);
        live = (j < r_edge);
        for (int i = 0; i < N; i++) er[i] = lane_op(g, cur_rows[i]);
        exp_res = pack_rows(er);
        check_val($sformatf("lat%0d c%0d busy", L, j), MAT_W'(busy[g]), MAT_W'(live && j <= N + L));
        check_val($sformatf("lat%0d c%0d done", L, j), MAT_W'(done[g]), MAT_W'(live && j == N + L));
        check_val($sformatf("lat%0d c%0d valid", L, j), MAT_W'(row_valid[g]), MAT_W'(live && j < N));
        check_val($sformatf("lat%0d c%0d row_out", L, j), MAT_W'(row_out[g]),
                  live ? MAT_W'(cur_rows[(j < N) ? j : N - 1]) : '0);
        if (!live)
            check_val($sformatf("lat%0d c%0d result_rst", L, j), result[g], '0);
        else if (j >= N + L)
            check_val($sformatf("lat%0d c%0d result", L, j), result[g], exp_res);
        exp_cnt = live ? ((j < N + L) ? j : N + L) : 0;
`ifdef MATRIX_ROWSEQ_CYCLE_CNT_EN
        check_val($sformatf("lat%0d c%0d cycle_cnt", L, j), MAT_W'(cycle_cnt[g]), MAT_W'(exp_cnt));
`else
        if (exp_cnt < 0) $display("unexpected negative count");
`endif
    endtask

    // Called at a negedge with the DUTs idle. restart_j / reset_j < 0 disable
    // the extra start pulse / reset pulse driven at that cycle offset.
    task automatic run_case(input int restart_j, input int reset_j);
        int r_edge;
        r_edge = (reset_j >= 0) ? reset_j + 1 : 1000;
        m_in  = pack_rows(cur_rows);
        start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < WIN; j++) begin
            @(negedge clk);
            for (int g = 0; g < LANES; g++) check_lane(g, j, r_edge);
            start = (j == restart_j);
            m_in  = (j == restart_j) ? pack_rows(alt_rows) : rand_mat();
            rst_b = (j == reset_j) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic randomize_rows();
        for (int i = 0; i < N; i++) begin
            cur_rows[i] = rand_row();
            alt_rows[i] = rand_row();
        end
    endtask

    initial begin
        logic [ROW_W-1:0] row_sel;

        rst_b = 1'b0;
        start = 1'b0;
        m_in  = rand_mat();
        repeat (5) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < LANES; g++) begin
            check_val($sformatf("rst lane%0d busy", g), MAT_W'(busy[g]), '0);
            check_val($sformatf("rst lane%0d done", g), MAT_W'(done[g]), '0);
            check_val($sformatf("rst lane%0d valid", g), MAT_W'(row_valid[g]), '0);
            check_val($sformatf("rst lane%0d row_out", g), MAT_W'(row_out[g]), '0);
            check_val($sformatf("rst lane%0d result", g), result[g], '0);
        end
        rst_b = 1'b1;

        // Basic case: row 0 = [1,3,2,5,0], rows 1..4 = [-1,-3,-2,-5,0].
        cur_rows[0] = 40'h01_03_02_05_00;
        for (int i = 1; i < N; i++) cur_rows[i] = 40'hFF_FD_FE_FB_00;
        for (int i = 0; i < N; i++) alt_rows[i] = '0;
        run_case(-1, -1);
        row_sel = result[1][row_lsb(0) +: ROW_W];
        check_val("basic neg row0", MAT_W'(row_sel), MAT_W'(40'hFF_FD_FE_FB_00));
        row_sel = result[1][row_lsb(3) +: ROW_W];
        check_val("basic neg row3", MAT_W'(row_sel), MAT_W'(40'h01_03_02_05_00));
        row_sel = result[2][row_lsb(4) +: ROW_W];
        check_val("basic id3 row4", MAT_W'(row_sel), MAT_W'(40'hFF_FD_FE_FB_00));

        for (int t = 0; t < 3; t++) begin
            randomize_rows();
            run_case(-1, -1);
        end

        // Second start two cycles into the run, with a different matrix.
        randomize_rows();
        run_case(2, -1);

        // Reset while lane 1 sits in DRAIN (cycle offset 5).
        randomize_rows();
        run_case(-1, 5);

        randomize_rows();
        run_case(-1, -1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/matrix_row_sequencer.md
Name: matrix_row_sequencer

Overview:
- Feeds a row-wise operation unit such as the matrix-opposite unit.
- Accepts a full packed N×N matrix and issues it one row per cycle to the attached unit.
- Captures the returned rows after a fixed pipeline latency and reassembles them into a packed result matrix, signalling completion with a one-cycle done pulse.
- Sits between the HPS-facing register bank and the row-level arithmetic units of the coprocessor.

Parameters:
- ELEM_W, 8, signed element width in bits.
- N, 5, matrix dimension (rows = columns = N).
- OP_LAT, 1, clock cycles from row_out to the matching row_in. Legal range 0..7; 0 means a combinational attached unit.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  begin operation. Sampled only in IDLE.
- m_in  in  N*N*ELEM_W  source matrix. Row 0 occupies the MSBs; within a row, element 0 occupies the MSBs.
- row_out  out  N*ELEM_W  row presented to the attached unit.
- row_valid_out  out  1  row_out holds a valid row.
- row_in  in  N*ELEM_W  row returned by the attached unit.
- result  out  N*N*ELEM_W  reassembled matrix, same packing as m_in.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse; result is complete.

Behaviour:
- Reset: clock is clk; reset is synchronous and active-low on rst. On rst=0 at a clock edge:
  - state goes to IDLE;
  - row_out, row_valid_out, result, busy, done, all counters and the valid delay line clear to 0.
  - Reset mid-operation aborts immediately. No done is produced and partial result is discarded (cleared).
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE → ISSUE on the edge sampling start=1 (edge E0).
  - m_in is latched into an internal source register at E0; later changes to m_in are ignored.
  - result is cleared at E0.
- ISSUE: during the cycle after edge E0+i, row_out = source row i and row_valid_out = 1, for i = 0..N-1.
  - Issue counter wraps 0..N-1.
  - On the edge that issues row N-1, go to DRAIN, or to DONE when OP_LAT=0 and the last capture completes on that edge.
- Capture: row_valid_out is delayed through an OP_LAT-stage shift register.
  - When the delayed valid is 1, row_in is written into result row c on the next edge, and the capture counter c increments (0..N-1).
  - For OP_LAT=0, capture happens on the same edge that ends the issue cycle.
- DRAIN: row_valid_out = 0, row_out holds its last value. Go to DONE on the edge capturing row N-1.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency: done is high during the cycle after edge E0+N+OP_LAT (E6 for N=5, OP_LAT=1). busy falls one edge later.
- result holds its value in IDLE until the next accepted start or a reset.
- start while busy=1 is ignored; no queuing. start held high continuously re-triggers on the edge after DONE returns to IDLE.
- Data path: pure transfer, no arithmetic. Rows pass bit-exact, with no width change and no sign handling.

Optional Feature:
- Macro: MATRIX_ROWSEQ_CYCLE_CNT_EN.
- Defined: adds output cycle_cnt [7:0].
  - Cleared at the accepted start edge.
  - Increments every cycle while busy=1.
  - Freezes when done is asserted, so it reads N+OP_LAT at done (6 for defaults).
  - Cleared by reset; saturates at 255.
- Undefined: port and counter absent. All other behaviour is identical.

Decomposition:
- Shared package matrix_pkg:
  - ELEM_W, N, derived ROW_W = N*ELEM_W and MAT_W = N*N*ELEM_W;
  - the state enum (IDLE, ISSUE, DRAIN, DONE);
  - row-slice index helper constants.
- One natural sub-module: row_valid_delay, the OP_LAT-deep valid shift register. At OP_LAT=0 it is a wire-through; it has synchronous active-low reset.

Test Plan:
- Bench setup: attach a negation model with OP_LAT=1 (negates each 8-bit element, registered).
- Basic:
  - Stimulus: reset 5 cycles, then start for 1 cycle with row 0 = [1,3,2,5,0] and rows 1..4 = [-1,-3,-2,-5,0].
  - Required: done pulses exactly 6 edges after the start edge.
  - Required: result row 0 = 0xFF_FD_FE_FB_00 and rows 1..4 = 0x01_03_02_05_00.
- Handshake:
  - Stimulus: same run.
  - Required: row_valid_out high for exactly 5 consecutive cycles, with row_out sequencing rows 0..4.
  - Required: busy high for 7 cycles, and done for 1 cycle.
- Ignored start:
  - Stimulus: pulse start again 2 cycles into a run, with a different m_in.
  - Required: result matches the original m_in; only one done pulse.
- Reset mid-op:
  - Stimulus: drive rst=0 during DRAIN.
  - Required: next cycle busy=0, done=0, result=0; no done pulse follows.
- Latency sweep:
  - Stimulus: OP_LAT=0 and OP_LAT=3 with the identity row model.
  - Required: result equals m_in; done pulses 5 and 8 edges after start respectively.
- Option:
  - Stimulus: build with MATRIX_ROWSEQ_CYCLE_CNT_EN and run the basic case.
  - Required: cycle_cnt = 6 at done, and holds 6 after.
